edge_count_arbiter: RTL and testbench
=====================================

// Module: edge_count_arbiter
// PURPOSE
//   Counts rising edges on N_CH asynchronous level inputs into a bank of N_BITS
//   counters. One shared increment datapath serves all channels, granted by a
//   round-robin arbiter.
//   Per-channel pending counters absorb edge bursts while a channel waits for the
//   datapath. Sits between raw event pins and the readout/interrupt logic.
// PARAMETERS
//   N_CH      4  number of input channels (>=2)
//   N_BITS    4  width of each event counter; wraps modulo 2**N_BITS
//   PEND_BITS 2  width of each per-channel pending counter; saturates at 2**PEND_BITS-1
// PORTS
//   clk      in   1                 single clock, rising edge
//   rst_n    in   1                 asynchronous, active-low reset
//   in       in   N_CH              asynchronous event levels, one per channel
//   clr      in   1                 synchronous clear of counts, pending and drop flags
//   rd_sel   in   $clog2(N_CH)      channel selected for readout
//   rd_count out  N_BITS            count of channel rd_sel (combinational mux)
//   wrap     out  N_CH              1-cycle pulse: that channel's count went max->0
//   drop     out  N_CH              sticky: an edge was lost to pending saturation
//   busy     out  1                 OR of (pending != 0) over all channels
// BEHAVIOUR
// - Reset: sync flops, edge history, counts, pending, drop, wrap, rr pointer = 0.
//   rd_count = 0; busy = 0.
//   History resets to 0, so a line already high at reset release counts once.
// - Input path: 2-flop synchronizer per channel (s1, s2), then history flop h.
//   rise[c] = s2[c] & ~h[c]. Falling edges and steady levels are ignored.
// - Pending: on rise[c], pend[c] += 1.
//   On grant[c], pend[c] -= 1.
//   Rise and grant in the same cycle leave pend[c] unchanged.
// - Saturation: rise[c] while pend[c] == max and no grant[c] leaves pend[c] at max.
//   It sets drop[c] = 1, which stays set until clr or reset.
// - Arbiter: req[c] = (pend[c] != 0), registered pend only.
//   At most one grant per cycle, round-robin from pointer ptr.
//   On grant of c, ptr <= (c+1) mod N_CH. With no requests, ptr holds.
// - Datapath: on grant[c], cnt[c] <= cnt[c] + 1 mod 2**N_BITS.
//   wrap[c] pulses for the one cycle after cnt[c] becomes 0 by wrap-around.
// - Latency: pin high set up before edge k -> s1@k, s2@k+1, pend@k+2, cnt@k+3
//   when uncontended. With all N_CH channels pending, each channel is served at
//   least once every N_CH cycles.
// - clr (synchronous, 1 cycle): cnt, pend, drop, wrap, ptr <= 0.
//   Any rise or grant in that cycle is discarded. s1, s2 and h keep running, so
//   a line held high is not recounted after clr.
// - rst_n asserted mid-operation: immediate return to the reset state; pending
//   edges are lost.
// - rd_sel >= N_CH: rd_count = 0.
// - Throughput: sustained edge rate per channel is up to 1 per 2 clk (synchronizer
//   limit). Aggregate service rate is 1 per clk; excess edges are recorded via drop.
// STRUCTURE
// - Package edge_cnt_pkg:
//   - localparams CH_W = $clog2(N_CH)
//   - PEND_MAX
//   - function rr_pick(req, ptr) returning the one-hot grant
// - Sub-module rr_arbiter (params N; in req[N], ptr[$clog2(N)]; out gnt[N] one-hot,
//   gnt_idx, gnt_vld): purely combinational. ptr is registered in the parent.
// - Parent holds: synchronizers, edge detect, pending counters, count bank,
//   wrap/drop regs, readout mux.
// TESTING
// 1 Reset/idle: rst_n low with in=4'b0000, release.
//   -> all rd_count = 0, busy = 0, wrap = drop = 0 for 20 cycles.
// 2 Single edge: in[1] 0->1 before edge k.
//   -> rd_sel=1 reads 1 after edge k+3; other channels stay 0.
//   Holding in[1] high gives no further counts.
// 3 Contention: all 4 channels rise in the same cycle.
//   -> grants in order 0,1,2,3 on consecutive cycles; all counts = 1; busy drops
//   after the 4th grant; ptr = 0.
// 4 Wrap: 16 separated edges on ch2 (N_BITS=4).
//   -> rd_count goes 15 -> 0; wrap[2] high exactly 1 cycle; other wrap bits stay 0.
// 5 Saturation: all channels toggle every 2 clk for 40 cycles.
//   -> pend saturates at 3; drop bits set and stay set.
//   Every count equals its edges minus its dropped edges.
// 6 clr / mid-op reset: clr while pending != 0.
//   -> next cycle cnt = pend = drop = 0 and busy = 0.
//   Repeat with rst_n pulsed low asynchronously mid-burst -> same state,
//   with no clk edge required.

Source files
------------

// File: rtl/edge_cnt_pkg.sv
// Shared constants and the round-robin pick function for the edge counter bank.
// The function works on a fixed wide vector so one definition serves any channel count.
package edge_cnt_pkg;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_N_BITS    = 4;
  localparam int DEF_PEND_BITS = 2;
  localparam int CH_W          = $clog2(DEF_N_CH);
  localparam int PEND_MAX      = (1 << DEF_PEND_BITS) - 1;
  localparam int MAX_CH        = 32;
  localparam int MAX_CH_W      = 5;

  // First requester at or after ptr (wrapping at n) wins; result is one-hot or zero.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input int unsigned      ptr,
                                                input int unsigned      n);
    logic [MAX_CH-1:0]   gnt;
    logic                found;
    int unsigned         idx;
    logic [MAX_CH_W-1:0] bit_sel;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx     = ptr + k;
      idx     = (idx >= n) ? (idx - n) : idx;
      bit_sel = MAX_CH_W'(idx);
      if ((k < n) && !found && req[bit_sel]) begin
        gnt[bit_sel] = 1'b1;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/edge_count_arbiter_rr.sv
// Purely combinational round-robin arbiter; the rotating pointer lives in the parent.
module rr_arbiter
  import edge_cnt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_vld_o
);

  logic [MAX_CH-1:0] req_ext_s;
  logic [MAX_CH-1:0] gnt_ext_s;

  always_comb begin
    req_ext_s        = '0;
    req_ext_s[N-1:0] = req_i;
    gnt_ext_s        = rr_pick(req_ext_s, 32'(ptr_i), N);
    gnt_o            = gnt_ext_s[N-1:0];
    gnt_vld_o        = |gnt_ext_s;
    gnt_idx_o        = '0;
    // Grant is one-hot, so OR-ing the candidate indices encodes it.
    for (int i = 0; i < MAX_CH; i++) begin
      gnt_idx_o = gnt_idx_o | (gnt_ext_s[i] ? $clog2(N)'(i) : '0);
    end
  end

endmodule

// File: rtl/edge_count_arbiter.sv
// Rising-edge counter bank: per-channel synchronizer and pending counter feeding
// one shared increment datapath chosen by a round-robin arbiter.
module edge_count_arbiter
  import edge_cnt_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int N_BITS    = DEF_N_BITS,
  parameter int PEND_BITS = DEF_PEND_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_i,
  input  logic                    clr_i,
  input  logic [$clog2(N_CH)-1:0] rd_sel_i,
  output logic [N_BITS-1:0]       rd_count_o,
  output logic [N_CH-1:0]         wrap_o,
  output logic [N_CH-1:0]         drop_o,
  output logic                    busy_o
);

  localparam int                   SEL_W    = $clog2(N_CH);
  localparam logic [PEND_BITS-1:0] PEND_TOP = {PEND_BITS{1'b1}};
  localparam logic [N_BITS-1:0]    CNT_TOP  = {N_BITS{1'b1}};
  localparam logic [SEL_W-1:0]     LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]       N_CH_V   = (SEL_W + 1)'(N_CH);

  logic [N_CH-1:0]                 s1_q, s2_q, h_q;
  logic [N_CH-1:0][PEND_BITS-1:0]  pend_q, pend_d;
  logic [N_CH-1:0][N_BITS-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0]                 drop_q, drop_d;
  logic [N_CH-1:0]                 wrap_q, wrap_d;
  logic [SEL_W-1:0]                ptr_q, ptr_d;
  logic                            busy_q, busy_d;

  logic [N_CH-1:0]                 rise_s, req_s, gnt_s;
  logic [SEL_W-1:0]                gnt_idx_s;
  logic                            gnt_vld_s;

  always_comb begin
    rise_s = s2_q & ~h_q;
    for (int c = 0; c < N_CH; c++) begin
      req_s[c] = (pend_q[c] != '0);
    end
  end

  rr_arbiter #(.N(N_CH)) u_arb (
    .req_i     (req_s),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // clr discards this cycle's rises and grants; the synchronizer keeps running.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    wrap_d = '0;
    ptr_d  = ptr_q;
    busy_d = 1'b0;
    if (clr_i) begin
      pend_d = '0;
      cnt_d  = '0;
      drop_d = '0;
      ptr_d  = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        case ({rise_s[c], gnt_s[c]})
          2'b10: begin
            if (pend_q[c] == PEND_TOP) begin
              drop_d[c] = 1'b1;
            end else begin
              pend_d[c] = pend_q[c] + PEND_BITS'(1);
            end
          end
          2'b01:   pend_d[c] = pend_q[c] - PEND_BITS'(1);
          default: pend_d[c] = pend_q[c];
        endcase
        if (gnt_s[c]) begin
          cnt_d[c]  = cnt_q[c] + N_BITS'(1);
          wrap_d[c] = (cnt_q[c] == CNT_TOP);
        end else begin
          cnt_d[c]  = cnt_q[c];
          wrap_d[c] = 1'b0;
        end
      end
      if (gnt_vld_s) begin
        ptr_d = (gnt_idx_s == LAST_CH) ? '0 : gnt_idx_s + SEL_W'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      busy_d = busy_d | (pend_d[c] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      h_q    <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      wrap_q <= '0;
      ptr_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      h_q    <= s2_q;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      wrap_q <= wrap_d;
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    if ({1'b0, rd_sel_i} < N_CH_V) begin
      rd_count_o = cnt_q[rd_sel_i];
    end else begin
      rd_count_o = '0;
    end
  end

  assign wrap_o = wrap_q;
  assign drop_o = drop_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_edge_count_arbiter.sv
// Randomized and directed bench for edge_count_arbiter against an integer reference model.
module tb_edge_count_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_v = 4'h0;
  logic       clr = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [3:0] rd_count, wrap, drop;
  logic       busy;

  always #10 clk = ~clk;

  edge_count_arbiter #(.N_CH(4), .N_BITS(4), .PEND_BITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (in_v),
    .clr_i      (clr),
    .rd_sel_i   (rd_sel),
    .rd_count_o (rd_count),
    .wrap_o     (wrap),
    .drop_o     (drop),
    .busy_o     (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int m_s1[4], m_s2[4], m_h[4], m_pend[4], m_cnt[4], m_drop[4], m_wrap[4];
  int m_ptr;
  int m_lost[4];
  int edges[4];
  int wrap_hits[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_h[c] = 0;
      m_pend[c] = 0; m_cnt[c] = 0; m_drop[c] = 0; m_wrap[c] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_step();
    int rise[4];
    int g;
    g = -1;
    for (int c = 0; c < 4; c++) begin
      rise[c] = (m_s2[c] == 1 && m_h[c] == 0) ? 1 : 0;
      m_h[c]  = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = in_v[c] ? 1 : 0;
    end
    if (clr) begin
      for (int c = 0; c < 4; c++) begin
        m_pend[c] = 0; m_cnt[c] = 0; m_drop[c] = 0; m_wrap[c] = 0; m_lost[c] = 0;
      end
      m_ptr = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && m_pend[(m_ptr + k) % 4] > 0) g = (m_ptr + k) % 4;
    end
    for (int c = 0; c < 4; c++) begin
      m_wrap[c] = 0;
      if (rise[c] == 1 && c != g) begin
        if (m_pend[c] == 3) begin
          m_drop[c] = 1;
          m_lost[c]++;
        end else begin
          m_pend[c]++;
        end
      end
      if (c == g && rise[c] == 0) m_pend[c]--;
      if (c == g) begin
        m_cnt[c] = (m_cnt[c] + 1) % 16;
        if (m_cnt[c] == 0) m_wrap[c] = 1;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % 4;
  endtask

  task automatic check_all();
    logic [3:0] ew, ed;
    logic       eb;
    eb = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_sel = 2'(c);
      #1;
      check_eq($sformatf("cnt%0d", c), 32'(rd_count), 32'(m_cnt[c]));
      ew[c] = (m_wrap[c] != 0);
      ed[c] = (m_drop[c] != 0);
      eb    = eb | (m_pend[c] != 0);
      wrap_hits[c] += wrap[c] ? 1 : 0;
    end
    check_eq("wrap", 32'(wrap), 32'(ew));
    check_eq("drop", 32'(drop), 32'(ed));
    check_eq("busy", 32'(busy), 32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic [3:0] v);
    for (int c = 0; c < 4; c++) begin
      if (v[c] && !in_v[c]) edges[c]++;
    end
    in_v = v;
  endtask

  task automatic read_ch(input int c, output logic [3:0] val);
    rd_sel = 2'(c);
    #1;
    val = rd_count;
  endtask

  task automatic quiet_clear();
    set_in(4'h0);
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      edges[c] = 0;
      wrap_hits[c] = 0;
    end
  endtask

  initial begin
    logic [3:0] v;
    logic [31:0] r;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      m_lost[c] = 0; edges[c] = 0; wrap_hits[c] = 0;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset / idle
    repeat (20) tick();
    for (int c = 0; c < 4; c++) begin
      read_ch(c, v);
      check_eq("idle_cnt", 32'(v), 32'd0);
    end
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Single edge on channel 1: count appears three edges after the sampling edge
    quiet_clear();
    set_in(4'b0010);
    for (int j = 1; j <= 4; j++) begin
      tick();
      read_ch(1, v);
      check_eq("lat_ch1", 32'(v), (j >= 4) ? 32'd1 : 32'd0);
    end
    repeat (6) tick();
    for (int c = 0; c < 4; c++) begin
      read_ch(c, v);
      check_eq("hold_ch", 32'(v), (c == 1) ? 32'd1 : 32'd0);
    end

    // All four channels rise together: served 0,1,2,3 on consecutive cycles
    quiet_clear();
    set_in(4'hF);
    for (int j = 1; j <= 8; j++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        read_ch(c, v);
        check_eq("rr_order", 32'(v), (j >= 4 + c) ? 32'd1 : 32'd0);
      end
      check_eq("rr_busy", 32'(busy), (j >= 3 && j <= 6) ? 32'd1 : 32'd0);
    end

    // Sixteen separated edges on channel 2 wrap its counter exactly once
    quiet_clear();
    for (int e = 1; e <= 16; e++) begin
      set_in(4'b0100); tick(); tick();
      set_in(4'b0000); tick(); tick();
      if (e == 15) begin
        read_ch(2, v);
        check_eq("pre_wrap", 32'(v), 32'd15);
      end
    end
    repeat (6) tick();
    read_ch(2, v);
    check_eq("post_wrap", 32'(v), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check_eq("wrap_hits", 32'(wrap_hits[c]), (c == 2) ? 32'd1 : 32'd0);
    end

    // Every channel rising every other cycle overruns the shared datapath
    quiet_clear();
    for (int j = 0; j < 40; j++) begin
      set_in(~in_v);
      tick();
    end
    set_in(4'h0);
    repeat (30) tick();
    check_eq("drop_all", 32'(drop), 32'hF);
    for (int c = 0; c < 4; c++) begin
      read_ch(c, v);
      check_eq("conserve", 32'(v), 32'((edges[c] - m_lost[c]) % 16));
    end
    repeat (10) tick();
    check_eq("drop_sticky", 32'(drop), 32'hF);

    // Random levels with occasional clr
    repeat (300) begin
      r = $urandom;
      set_in(r[3:0]);
      clr = ($urandom_range(0, 49) == 0);
      tick();
      clr = 1'b0;
    end

    // clr while work is pending
    quiet_clear();
    set_in(4'hF);
    repeat (4) tick();
    check_eq("pre_clr_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_drop", 32'(drop), 32'd0);
    for (int c = 0; c < 4; c++) begin
      read_ch(c, v);
      check_eq("clr_cnt", 32'(v), 32'd0);
    end
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      read_ch(c, v);
      check_eq("no_recount", 32'(v), 32'd0);
    end

    // Asynchronous reset in the middle of a burst
    for (int j = 0; j < 16; j++) begin
      set_in(~in_v);
      tick();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_drop", 32'(drop), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
